// File: rtl/node_arb_pkg.sv
// Shared constants and types for the node-router control-token arbiter.
package node_arb_pkg;

    localparam int unsigned CTRL_W = 32'd3;
    localparam int unsigned NUM_IN = 32'd4;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Source-port identifiers carried in control tokens
    localparam ctrl_t PORT_IN1  = 3'b000;
    localparam ctrl_t PORT_IN2  = 3'b001;
    localparam ctrl_t PORT_IN3  = 3'b010;
    localparam ctrl_t PORT_IN4  = 3'b011;
    localparam ctrl_t PORT_CORE = 3'b100;

endpackage

// File: rtl/ctrl_arb4_rr_if.sv
// Request/response bundle between the path-computation units, the arbiter and the node merge.
interface ctrl_arb4_rr_if
    import node_arb_pkg::*;
();

    logic [NUM_IN-1:0]         in_valid;
    ctrl_t [NUM_IN-1:0]        in_data;
    logic [NUM_IN-1:0]         in_ready;
    logic                      out_valid;
    ctrl_t                     out_data;
    logic [1:0]                out_src;
    logic                      out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo 4.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] idx_s;
    logic       hit_s;

    // Walk the four positions starting at ptr; the first request seen wins.
    always_comb begin
        gnt_idx = 2'd0;
        any     = 1'b0;
        idx_s   = 2'd0;
        hit_s   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx_s   = ptr + 2'(k);
            hit_s   = ~any & req[idx_s];
            gnt_idx = hit_s ? idx_s : gnt_idx;
            any     = any | req[idx_s];
        end
        gnt = {3'b000, any} << gnt_idx;
    end

endmodule

// File: rtl/ctrl_arb4_rr.sv
// 4:1 control-token arbiter with a registered output stage and round-robin fairness.
// Define ARB_FIXED_PRIORITY_EN for fixed priority (input 0 highest, no rotation pointer).
module ctrl_arb4_rr
    import node_arb_pkg::*;
(
    input  logic          clk,
    input  logic          _RESET,
    ctrl_arb4_rr_if.slave bus
);

    logic              load_s;
    logic [NUM_IN-1:0] gnt_s;
    logic [1:0]        gnt_idx_s;
    logic              any_s;
    logic [1:0]        ptr_s;

    logic              out_valid_q, out_valid_d;
    ctrl_t             out_data_q,  out_data_d;
    logic [1:0]        out_src_q,   out_src_d;

    assign load_s = ~out_valid_q | bus.out_ready;

    rr_pick4 u_pick (
        .req     (bus.in_valid),
        .ptr     (ptr_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

`ifdef ARB_FIXED_PRIORITY_EN
    assign ptr_s = 2'd0;
`else
    logic [1:0] rr_ptr_q, rr_ptr_d;

    // Pointer moves just past the winner, only when a token is actually taken.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (load_s && any_s) begin
            rr_ptr_d = gnt_idx_s + 2'd1;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Rotation pointer register.
    always_ff @(posedge clk or negedge _RESET) begin
        if (!_RESET) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign ptr_s = rr_ptr_q;
`endif

    // Ready is forced low while reset is held so no token is consumed by a resetting arbiter.
    assign bus.in_ready = (load_s && _RESET) ? gnt_s : {NUM_IN{1'b0}};

    // Output stage next state: capture the winner on load, hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load_s) begin
            out_valid_d = any_s;
            if (any_s) begin
                out_data_d = bus.in_data[gnt_idx_s];
                out_src_d  = gnt_idx_s;
            end else begin
                out_data_d = out_data_q;
                out_src_d  = out_src_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge _RESET) begin
        if (!_RESET) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 3'b000;
            out_src_q   <= 2'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_ctrl_arb4_rr.sv
// Randomised bench for ctrl_arb4_rr against a distance-based arbitration reference model.
module tb_ctrl_arb4_rr;
    import node_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n_s;

    always #5 clk = ~clk;

    ctrl_arb4_rr_if bus ();

    ctrl_arb4_rr dut (
        .clk    (clk),
        ._RESET (rst_n_s),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]      v;
    logic [3:0][2:0] d;
    logic            ordy;

    bit         m_valid;
    logic [2:0] m_data;
    int         m_src;
    int         m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Winner is the valid request with the smallest forward distance from the pointer.
    function automatic int model_pick(input logic [3:0] req, input int p);
        int best;
        int bd;
        best = -1;
        bd   = 4;
        for (int i = 0; i < 4; i++) begin
            if (req[i] && (((i - p + 4) % 4) < bd)) begin
                bd   = (i - p + 4) % 4;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic logic [3:0] exp_ready();
        int w;
        if (rst_n_s !== 1'b1) return 4'b0000;
        w = model_pick(v, m_ptr);
        if ((!m_valid || ordy) && w >= 0) return 4'(1 << w);
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 3'b000;
        m_src   = 0;
        m_ptr   = 0;
    endtask

    task automatic drive();
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    // One clock: check ready, advance model at the edge, check registered outputs.
    task automatic step(input bit keep);
        int w;
        bit load;
        drive();
        #1;
        check_eq("in_ready", 32'(bus.in_ready), 32'(exp_ready()));
        load = !m_valid || ordy;
        w    = model_pick(v, m_ptr);
        @(posedge clk);
        if (load) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = d[w];
                m_src   = w;
`ifdef ARB_FIXED_PRIORITY_EN
                m_ptr   = 0;
`else
                m_ptr   = (w + 1) % 4;
`endif
                if (!keep) v[w] = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check_eq("out_data",  32'(bus.out_data),  32'(m_data));
        check_eq("out_src",   32'(bus.out_src),   m_src);
    endtask

    initial begin
        model_reset();
        rst_n_s = 1'b0;
        v       = 4'hF;
        d[0]    = 3'b000;
        d[1]    = 3'b001;
        d[2]    = 3'b010;
        d[3]    = 3'b011;
        ordy    = 1'b1;
        drive();
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check_eq("rst_out_data",  32'(bus.out_data),  32'd0);
        check_eq("rst_out_src",   32'(bus.out_src),   32'd0);
        rst_n_s = 1'b1;

        // All four requesting continuously
        repeat (5) step(1'b1);

        v = 4'b0000;
        step(1'b0);

        v    = 4'b0100;
        d[2] = 3'b010;
        step(1'b0);
        check_eq("single_data", 32'(bus.out_data), 32'd2);
        check_eq("single_src",  32'(bus.out_src),  32'd2);

        // Backpressure with all inputs pending
        v    = 4'hF;
        ordy = 1'b1;
        step(1'b1);
        ordy = 1'b0;
        repeat (3) step(1'b1);

        ordy = 1'b1;
        v    = 4'b1010;
        repeat (4) step(1'b1);

        v = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!v[i] && ($urandom_range(1, 0) == 1)) begin
                    v[i] = 1'b1;
                    d[i] = 3'($urandom_range(7, 0));
                end
            end
            ordy = ($urandom_range(3, 0) != 0);
            step(1'b0);
            if (c == 700) begin
                #2 rst_n_s = 1'b0;
                #1;
                check_eq("async_out_valid", 32'(bus.out_valid), 32'd0);
                check_eq("async_in_ready",  32'(bus.in_ready),  32'd0);
                model_reset();
                @(posedge clk);
                @(negedge clk);
                v = 4'hF;
                rst_n_s = 1'b1;
                step(1'b0);
                check_eq("post_rst_src", 32'(bus.out_src), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
